// File: rtl/key_step_pkg.sv
// Shared types and constants for the key step conditioner.
// Step codes, FSM states and synchronizer reset values.
package key_step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [1:0] STEP_HOLD = 2'b00;
  localparam logic [1:0] STEP_INC1 = 2'b01;
  localparam logic [1:0] STEP_INC2 = 2'b10;
  localparam logic [1:0] STEP_DEC1 = 2'b11;

  localparam logic       KEY_RST  = 1'b1;
  localparam logic [1:0] MODE_RST = 2'b00;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Synchronous active-high reset loads RESET_VAL into both stages.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage resynchronization into clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_conditioner.sv
// Debounces an active-low key and latches the step mode,
// producing a one-cycle step strobe with optional auto-repeat.
module key_step_conditioner
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [1:0] mode_sw,
  output logic       step_valid,
  output logic [1:0] step_code,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             key_s;
  logic [1:0]       mode_s;

  state_t           state, state_d;
  logic [CNT_W-1:0] dcnt, dcnt_d;
  logic [CNT_W-1:0] rcnt, rcnt_d;
  logic             first, first_d;
  logic             valid_d;
  logic [1:0]       code_d;
  logic             held_d;
  logic [CNT_W-1:0] thr_last;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (KEY_RST)
  ) u_sync_key (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  sync_2ff #(
    .WIDTH     (2),
    .RESET_VAL (MODE_RST)
  ) u_sync_mode (
    .clk   (clk),
    .reset (reset),
    .d     (mode_sw),
    .q     (mode_s)
  );

  assign thr_last = first ? DLY_LAST : PER_LAST;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dcnt       <= '0;
      rcnt       <= '0;
      first      <= 1'b0;
      step_valid <= 1'b0;
      step_code  <= STEP_HOLD;
      key_held   <= 1'b0;
    end else begin
      state      <= state_d;
      dcnt       <= dcnt_d;
      rcnt       <= rcnt_d;
      first      <= first_d;
      step_valid <= valid_d;
      step_code  <= code_d;
      key_held   <= held_d;
    end
  end

  // Debounce / repeat next-state and output decode
  always_comb begin
    state_d = state;
    dcnt_d  = dcnt;
    rcnt_d  = rcnt;
    first_d = first;
    valid_d = 1'b0;
    code_d  = step_code;
    held_d  = key_held;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (dcnt == DB_LAST) begin
          state_d = HELD;
          code_d  = mode_s;
          held_d  = 1'b1;
          rcnt_d  = '0;
          first_d = 1'b1;
          valid_d = (mode_s != STEP_HOLD);
        end else begin
          dcnt_d = dcnt + ONE;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (REPEAT_EN != 0) begin
          if (rcnt == thr_last) begin
            valid_d = (step_code != STEP_HOLD);
            rcnt_d  = '0;
            first_d = 1'b0;
          end else begin
            rcnt_d = rcnt + ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
          rcnt_d  = '0;
          first_d = 1'b1;
        end else if (dcnt == DB_LAST) begin
          state_d = IDLE;
          held_d  = 1'b0;
        end else begin
          dcnt_d = dcnt + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed bench for key_step_conditioner.
// Table-driven press/release plus multi-cycle sequences.
module tb_key_step_conditioner;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic [1:0] mode_sw;
  logic       a_valid, b_valid;
  logic [1:0] a_code, b_code;
  logic       a_held, b_held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  int         a_cyc[$];
  logic [1:0] a_cd[$];
  int         b_cyc[$];
  logic [1:0] b_cd[$];
  int         exp_q[$];

  typedef struct {
    logic       rst;
    logic       key;
    logic [1:0] mode;
    logic       v;
    logic [1:0] code;
    logic       held;
  } vec_t;

  vec_t tbl[17];

  key_step_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .CNT_W           (8)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .mode_sw    (mode_sw),
    .step_valid (a_valid),
    .step_code  (a_code),
    .key_held   (a_held)
  );

  key_step_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (0),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .CNT_W           (8)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .mode_sw    (mode_sw),
    .step_valid (b_valid),
    .step_code  (b_code),
    .key_held   (b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (a_valid) begin
        a_cyc.push_back(cyc);
        a_cd.push_back(a_code);
      end
      if (b_valid) begin
        b_cyc.push_back(cyc);
        b_cd.push_back(b_code);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    a_cyc.delete();
    a_cd.delete();
    b_cyc.delete();
    b_cd.delete();
  endtask

  task automatic press(input logic [1:0] m);
    mode_sw = m;
    tick(3);
    key_n = 1'b0;
    base  = cyc;
    clear_logs();
  endtask

  task automatic release_key();
    key_n = 1'b1;
    tick(10);
  endtask

  initial begin
    reset   = 1'b1;
    key_n   = 1'b1;
    mode_sw = 2'b01;

    tbl[0] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1};
    for (int i = 10; i <= 15; i++)
      tbl[i] = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0};

    for (int i = 0; i < 17; i++) begin
      reset   = tbl[i].rst;
      key_n   = tbl[i].key;
      mode_sw = tbl[i].mode;
      tick(1);
      chk($sformatf("tbl%0d.valid", i), int'(a_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d.code", i), int'(a_code), int'(tbl[i].code));
      chk($sformatf("tbl%0d.held", i), int'(a_held), int'(tbl[i].held));
    end

    // Bounce: low 2, high 1, then steady low
    mode_sw = 2'b01;
    tick(3);
    clear_logs();
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(1);
    key_n = 1'b0;
    base  = cyc;
    tick(12);
    chk("bounce.count", a_cyc.size(), 1);
    if (a_cyc.size() > 0)
      chk("bounce.at", a_cyc[0] - base, 7);
    release_key();

    // Auto-repeat with mode 10
    press(2'b10);
    tick(40);
    exp_q.delete();
    exp_q.push_back(7);
    for (int t = 17; t <= 40; t += 3)
      exp_q.push_back(t);
    chk("rep.count", a_cyc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < a_cyc.size(); i++) begin
      chk($sformatf("rep%0d.at", i), a_cyc[i] - base, exp_q[i]);
      chk($sformatf("rep%0d.code", i), int'(a_cd[i]), 2);
    end
    chk("norep.count", b_cyc.size(), 1);
    if (b_cyc.size() > 0) begin
      chk("norep.at", b_cyc[0] - base, 7);
      chk("norep.code", int'(b_cd[0]), 2);
    end
    release_key();

    // Mode change while held is ignored
    press(2'b11);
    tick(7);
    mode_sw = 2'b01;
    tick(18);
    chk("mchg.count", a_cyc.size(), 4);
    for (int i = 0; i < a_cyc.size(); i++)
      chk($sformatf("mchg%0d.code", i), int'(a_cd[i]), 3);
    release_key();
    press(2'b01);
    tick(9);
    chk("mchg.new.count", a_cyc.size(), 1);
    if (a_cd.size() > 0)
      chk("mchg.new.code", int'(a_cd[0]), 1);
    release_key();

    // Hold code never strobes
    press(2'b00);
    tick(25);
    chk("hold.count", a_cyc.size() + b_cyc.size(), 0);
    chk("hold.held", int'(a_held), 1);
    chk("hold.held_b", int'(b_held), 1);
    chk("hold.code", int'(a_code), 0);
    release_key();

    // Reset during HELD with key still down
    press(2'b01);
    tick(10);
    chk("rst.pre.held", int'(a_held), 1);
    reset = 1'b1;
    tick(1);
    chk("rst.valid", int'(a_valid), 0);
    chk("rst.code", int'(a_code), 0);
    chk("rst.held", int'(a_held), 0);
    reset = 1'b0;
    clear_logs();
    base = cyc;
    tick(10);
    chk("rst.re.count", a_cyc.size(), 1);
    if (a_cyc.size() > 0) begin
      chk("rst.re.at", a_cyc[0] - base, 7);
      chk("rst.re.code", int'(a_cd[0]), 1);
    end
    release_key();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
Upstream front end for the mod-10 step counter / HEX display stage. It turns a raw, bouncy active-low push-button and a raw 2-bit step-mode switch into a clean, single-cycle step strobe with a latched step code. The counter stage then runs on the system clock and uses step_valid as its enable, instead of clocking on the key edge. Optional auto-repeat issues further strobes while the key is held.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles the synchronized key must stay stable to accept a press or release (10 ms at 50 MHz); must be >= 2.
REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives one strobe per press.
REPEAT_DELAY, 25000000, cycles from entering HELD to the first repeat strobe; must be >= 2.
REPEAT_PERIOD, 5000000, cycles between later repeat strobes; must be >= 2.
CNT_W, 25, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset, synchronous, active-high
key_n  in  1  raw push-button, 0 = pressed, asynchronous
mode_sw  in  2  raw step-mode switches, asynchronous
step_valid  out  1  one-cycle strobe: apply step_code now
step_code  out  2  00 hold, 01 +1, 10 +2, 11 -1; stable while the key is held
key_held  out  1  high from accepted press until accepted release

Behaviour:
- Input synchronization
  - key_n and mode_sw each pass through a 2-flop synchronizer, giving key_s and mode_s.
  - All FSM logic uses only key_s and mode_s.
- Reset
  - When reset=1 at a rising edge: state=IDLE, both counters=0, step_valid=0, step_code=00, key_held=0, synchronizer flops=1 for key and 0 for mode.
  - Reset dominates every other event.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. All outputs are registered.
- IDLE
  - If key_s=0: go to PRESS_WAIT, dcnt=0.
- PRESS_WAIT
  - If key_s=1 (bounce): go to IDLE, no strobe.
  - Otherwise dcnt increments each cycle.
  - When dcnt==DEBOUNCE_CYCLES-1 and key_s=0: go to HELD, step_code<=mode_s, key_held<=1, rcnt=0, first-repeat flag set.
  - On that same edge step_valid<=1, unless mode_s==00, in which case no strobe.
- Press latency
  - For a clean press, step_valid is high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge following key_n falling (2 sync edges, 1 entry edge, DEBOUNCE_CYCLES counting edges).
- HELD
  - If key_s=1: go to RELEASE_WAIT, dcnt=0.
  - Else, if REPEAT_EN=1: rcnt increments each cycle.
  - When rcnt reaches threshold-1 (threshold = REPEAT_DELAY if the first-repeat flag is set, else REPEAT_PERIOD): step_valid<=1 (if step_code!=00), rcnt=0, flag cleared.
  - Changes on mode_s while in HELD are ignored; step_code stays latched.
- RELEASE_WAIT
  - If key_s=0 (bounce): return to HELD, rcnt=0, flag set, no strobe.
  - When dcnt==DEBOUNCE_CYCLES-1 with key_s=1: go to IDLE, key_held<=0.
- step_valid is never high on two consecutive cycles.
- step_code changes only on entry to HELD.
- Reset during a press: the block returns to IDLE. If the key is still down after reset falls, it is handled as a fresh press (full debounce, new strobe).
- Counters never wrap: they saturate or clear per the rules above.

Decomposition:
- Package key_step_pkg:
  - state enum
  - step code constants STEP_HOLD=2'b00, STEP_INC1=2'b01, STEP_INC2=2'b10, STEP_DEC1=2'b11
  - reset value constants
- Sub-module sync_2ff, parameterized WIDTH and RESET_VAL, instantiated once for key_n (reset 1) and once for mode_sw (reset 0).

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: mode_sw=01, key_n low at edge 0, held low -> single step_valid after edge 7, step_code=01, key_held=1.
- Bounce: key_n low for 2 cycles, high for 1, then low steadily -> no strobe from the glitch; exactly one strobe, 7 edges after the final fall.
- Auto-repeat: mode_sw=10, hold key for 30 cycles after acceptance -> strobes at acceptance, +10, +13, +16, ... (one every 3 cycles), all with code 10. With REPEAT_EN=0 -> only the first strobe.
- Mode change while held: press with 11, then flip mode_sw to 01 -> every strobe carries 11 until release and a new press.
- Hold code: mode_sw=00, press -> key_held=1, no step_valid ever.
- Reset mid-hold: assert reset during HELD with key still down -> outputs 0 next cycle; after reset drops, a new strobe appears 7 edges later.
